// File: rtl/subfield_inv_arbiter.sv
// Round-robin front end for a shared GF((2^2)^2) subfield inverter.
// Each cycle, at most one requester is granted. Its 4-bit operand is
// inverted combinationally. The result, tagged with the requester index,
// is held in a single response register until downstream consumes it.
module subfield_inv_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [3:0]        rsp_data,
  output logic [IDW-1:0]    rsp_id,
  input  logic              rsp_ready,
  output logic [CNTW-1:0]   op_count
);

  // GF(4) in normal basis (W^2, W). Bit 1 is the W^2 coefficient.
  function automatic logic [1:0] gf4_mul(input logic [1:0] g, input logic [1:0] h);
    logic [1:0] p;
    p[1] = (g[0] & h[0]) ^ (g[1] & h[0]) ^ (g[0] & h[1]);
    p[0] = (g[1] & h[1]) ^ (g[1] & h[0]) ^ (g[0] & h[1]);
    return p;
  endfunction

  // In a normal basis, squaring is a swap of the two coefficients.
  function automatic logic [1:0] gf4_sq(input logic [1:0] g);
    return {g[0], g[1]};
  endfunction

  // GF(16) over GF(4) in normal basis (Z^4, Z), where Z^2 + Z + N = 0 and N = W^2.
  // inv(A) = conj(A) / norm(A), with norm = a1*a0 + N*(a1+a0)^2.
  // In GF(4), the inverse equals the square, so 0 maps to 0 naturally.
  function automatic logic [3:0] subfield_inv(input logic [3:0] d);
    logic [1:0] a1, a0, nrm, th;
    a1  = d[3:2];
    a0  = d[1:0];
    nrm = gf4_mul(a1, a0) ^ gf4_mul(gf4_sq(a1 ^ a0), 2'b10);
    th  = gf4_sq(nrm);
    return {gf4_mul(a0, th), gf4_mul(a1, th)};
  endfunction

  logic [IDW-1:0]  ptr;
  logic            can_accept;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_idx;
  logic [3:0]      operand_p0;
  logic [3:0]      inv_p0;
  logic            vld_p1;
  logic [3:0]      rsp_data_p1;
  logic [IDW-1:0]  rsp_id_p1;
  logic [CNTW-1:0] op_cnt;

  assign can_accept = ~vld_p1 | rsp_ready;

  // Rotating priority search starting at ptr. The first valid requester wins.
  always_comb begin
    logic [IDW:0] cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!gnt_any && req_valid[cand[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
    if (rst || !can_accept) gnt_any = 1'b0;
  end

  assign req_ready = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

  // ---- stage p0: operand select and combinational inversion ----
  assign operand_p0 = req_data[{gnt_idx, 2'b00} +: 4];
  assign inv_p0     = subfield_inv(operand_p0);

  // Priority pointer advances past the winner on every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  // ---- stage p1: response register ----
  // Loads on a grant. Clears only the valid bit when drained without a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      rsp_data_p1 <= '0;
      rsp_id_p1   <= '0;
    end else if (gnt_any) begin
      vld_p1      <= 1'b1;
      rsp_data_p1 <= inv_p0;
      rsp_id_p1   <= gnt_idx;
    end else if (rsp_ready) begin
      vld_p1      <= 1'b0;
    end
  end

  // Saturating count of responses taken by downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt <= '0;
    end else if (vld_p1 && rsp_ready && (op_cnt != {CNTW{1'b1}})) begin
      op_cnt <= op_cnt + CNTW'(1);
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_data  = rsp_data_p1;
  assign rsp_id    = rsp_id_p1;
  assign op_count  = op_cnt;

endmodule
